// File: rtl/memory_banked_dp.sv
// Dual-port, low-order interleaved banked RAM with byte enables and a post-reset clear sweep.
// Optional MEMORY_BANKED_OUT_REG_EN adds one output register stage (read latency 2).
module memory_banked_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_BITS  = $clog2(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_0,
  input  logic                    we_0,
  input  logic                    oe_0,
  input  logic [ADDR_WIDTH-1:0]   address_0,
  input  logic [DATA_WIDTH-1:0]   data_0_in,
  input  logic [DATA_WIDTH/8-1:0] be_0,
  output logic                    ready_0,
  output logic [DATA_WIDTH-1:0]   data_0_out,
  output logic                    valid_0,
  input  logic                    cs_1,
  input  logic                    we_1,
  input  logic                    oe_1,
  input  logic [ADDR_WIDTH-1:0]   address_1,
  input  logic [DATA_WIDTH-1:0]   data_1_in,
  input  logic [DATA_WIDTH/8-1:0] be_1,
  output logic                    ready_1,
  output logic [DATA_WIDTH-1:0]   data_1_out,
  output logic                    valid_1,
  output logic                    busy
);

  localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int LANES    = DATA_WIDTH / 8;
  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

  // ST_CLEAR | zero one row in every bank per cycle, ports held off
  // ST_RUN   | normal dual-port service until the next reset
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q;
  logic [ROW_BITS-1:0] clr_row_q;
  logic                busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_row_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_row_q <= clr_row_q + 1'b1;
          if (clr_row_q == ROW_LAST) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy = busy_q;

  logic [BANK_BITS-1:0] bank_0, bank_1;
  logic [ROW_BITS-1:0]  row_0, row_1;
  logic                 conflict;
  logic                 acc_0, acc_1;
  logic                 wr_0, wr_1;
  logic                 rd_0, rd_1;
  logic                 clearing;

  assign bank_0   = address_0[BANK_BITS-1:0];
  assign bank_1   = address_1[BANK_BITS-1:0];
  assign row_0    = address_0[ADDR_WIDTH-1:BANK_BITS];
  assign row_1    = address_1[ADDR_WIDTH-1:BANK_BITS];
  assign clearing = (state_q == ST_CLEAR);

  // Port 0 has fixed priority; port 1 is held off on a same-bank collision.
  assign conflict = cs_0 && cs_1 && (bank_0 == bank_1);
  assign ready_0  = !busy_q;
  assign ready_1  = !busy_q && !conflict;

  assign acc_0 = cs_0 && ready_0;
  assign acc_1 = cs_1 && ready_1;
  assign wr_0  = acc_0 && we_0;
  assign wr_1  = acc_1 && we_1;
  assign rd_0  = acc_0 && !we_0 && oe_0;
  assign rd_1  = acc_1 && !we_1 && oe_1;

  logic [DATA_WIDTH-1:0] bank_rdata_0 [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata_1 [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] ram_q [ROWS];
    logic                  sel_0, sel_1;
    logic                  wen_d;
    logic [ROW_BITS-1:0]   wrow_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [LANES-1:0]      wbe_d;

    assign sel_0 = wr_0 && (bank_0 == BANK_BITS'(b));
    assign sel_1 = wr_1 && (bank_1 == BANK_BITS'(b));

    // One write port per bank: the sweep, then port 0, then port 1.
    always_comb begin
      wen_d   = 1'b0;
      wrow_d  = '0;
      wdata_d = '0;
      wbe_d   = '0;
      if (clearing) begin
        wen_d  = 1'b1;
        wrow_d = clr_row_q;
        wbe_d  = '1;
      end else if (sel_0) begin
        wen_d   = 1'b1;
        wrow_d  = row_0;
        wdata_d = data_0_in;
        wbe_d   = be_0;
      end else if (sel_1) begin
        wen_d   = 1'b1;
        wrow_d  = row_1;
        wdata_d = data_1_in;
        wbe_d   = be_1;
      end
    end

    always_ff @(posedge clk) begin
      if (wen_d) begin
        for (int i = 0; i < LANES; i++) begin
          if (wbe_d[i]) ram_q[wrow_d][8*i +: 8] <= wdata_d[8*i +: 8];
        end
      end
    end

    assign bank_rdata_0[b] = ram_q[row_0];
    assign bank_rdata_1[b] = ram_q[row_1];
  end

  logic [DATA_WIDTH-1:0] rdata_0_d, rdata_1_d;
  logic [DATA_WIDTH-1:0] rdata_0_q, rdata_1_q;
  logic                  rvalid_0_q, rvalid_1_q;

  assign rdata_0_d = rd_0 ? bank_rdata_0[bank_0] : '0;
  assign rdata_1_d = rd_1 ? bank_rdata_1[bank_1] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
    end else begin
      rdata_0_q  <= rdata_0_d;
      rdata_1_q  <= rdata_1_d;
      rvalid_0_q <= rd_0;
      rvalid_1_q <= rd_1;
    end
  end

`ifdef MEMORY_BANKED_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_0_q, out_data_1_q;
  logic                  out_valid_0_q, out_valid_1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_0_q  <= '0;
      out_data_1_q  <= '0;
      out_valid_0_q <= 1'b0;
      out_valid_1_q <= 1'b0;
    end else begin
      out_data_0_q  <= rdata_0_q;
      out_data_1_q  <= rdata_1_q;
      out_valid_0_q <= rvalid_0_q;
      out_valid_1_q <= rvalid_1_q;
    end
  end

  assign data_0_out = out_data_0_q;
  assign data_1_out = out_data_1_q;
  assign valid_0    = out_valid_0_q;
  assign valid_1    = out_valid_1_q;
`else
  assign data_0_out = rdata_0_q;
  assign data_1_out = rdata_1_q;
  assign valid_0    = rvalid_0_q;
  assign valid_1    = rvalid_1_q;
`endif

endmodule

// File: doc/memory_banked_dp.md
# memory_banked_dp

Parametrised dual-port, multi-bank synchronous RAM for the HD accelerator's hypervector and class-vector storage. It replaces the single-port RAM wherever two engines share one store, such as the encoder writing while the similarity unit reads. It adds:
- low-order address interleaving across banks, with fixed-priority conflict arbitration;
- per-byte write enables;
- a read-valid flag;
- a self-clearing sequencer that zeroes the whole array after reset.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width.
- NUM_BANKS, 4, number of interleaved banks; power of two, 2..2^(ADDR_WIDTH-1).
- BANK_BITS, $clog2(NUM_BANKS), derived; must not be overridden.

Ports (p = 0, 1; port 0 and port 1 are identical):
- clk  in  1  clock; everything is synchronous to the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cs_p  in  1  chip select; a request is present this cycle.
- we_p  in  1  1 = write, 0 = read.
- oe_p  in  1  output enable; a read takes place only when this is 1.
- address_p  in  ADDR_WIDTH  word address.
- data_p_in  in  DATA_WIDTH  write data.
- be_p  in  DATA_WIDTH/8  byte enables; bit i covers data bits [8i+7:8i].
- ready_p  out  1  the request is accepted this cycle.
- data_p_out  out  DATA_WIDTH  read data; 0 when valid_p = 0.
- valid_p  out  1  data_p_out holds read data.
- busy  out  1  clear sweep in progress.

## Operation
- Address mapping: bank = address[BANK_BITS-1:0]; row = address[ADDR_WIDTH-1:BANK_BITS]. Each bank is RAM_DEPTH/NUM_BANKS deep.
- Acceptance: a request is accepted when cs_p && ready_p at the rising edge. An unaccepted request has no effect, and the requester must hold it.
- Write: cs && we. Lanes with be = 1 are updated; lanes with be = 0 keep their contents. A write never asserts valid.
- Read: cs && !we && oe. The row is read and valid is asserted.
- cs && !we && !oe: accepted, no operation, valid stays 0.
- ready_0 = !busy.
- ready_1 = !busy && !(cs_0 && cs_1 && bank_0 == bank_1).
- The conflict check is combinational. A port-1 request that loses a bank conflict is held off; port 0 always wins.
- Two requests to different banks proceed in parallel in the same cycle.
- Within one port, a read issued the cycle after a write to the same address returns the newly written data.
- Clear state machine:
  - CLEAR: entered on reset assertion. A row counter (ADDR_WIDTH-BANK_BITS bits) starts at 0. Each cycle it writes 0 to that row in all banks at once and increments. busy = 1 and both ready outputs are 0.
  - When the counter reaches its last row, the state moves to RUN on the next edge; busy falls after exactly RAM_DEPTH/NUM_BANKS clear cycles.
  - RUN: normal service; busy = 0. RUN is left only by reset.
- Reset asserted mid-clear or mid-RUN: the state returns to CLEAR, the counter returns to 0 and the sweep restarts. Pending read data is discarded.

## Timing
- Reset values: data_0_out = 0, data_1_out = 0, valid_0 = 0, valid_1 = 0, ready_0 = 0, ready_1 = 0, busy = 1.
- Read latency: data and valid appear 1 cycle after the accepting edge. They hold for one cycle only, then return to 0 unless another read follows.
- Throughput: one access per port per cycle when there is no conflict.
- The first access can be accepted on the first edge with busy = 0.

## Configuration
- MEMORY_BANKED_OUT_REG_EN:
  - Defined: data_p_out and valid_p pass through one extra output register. Read latency becomes 2 cycles; throughput is unchanged. The extra registers reset to 0 and are flushed on reset.
  - Undefined: read latency is 1 cycle.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then wait: busy = 1 for exactly RAM_DEPTH/NUM_BANKS cycles. Reading addresses 0x00, 0x7F and 0xFF then returns 0 with valid = 1 one cycle later.
- Port 0 writes 0xDEADBEEF at 0x10 with be = 4'b1111, then writes 0x000000AA with be = 4'b0001. Reading 0x10 returns 0xDEADBEAA.
- Same-cycle conflict: port 0 writes 0x04 and port 1 reads 0x08 (both bank 0). Required response: ready_1 = 0 and ready_0 = 1, then port 1 is accepted next cycle. A non-conflicting pair, 0x04 and 0x05, is accepted in the same cycle.
- Back-to-back on port 1: write 0x55 to 0x21, read 0x21 on the next cycle. Required response: data_1_out = 0x55 with valid_1 = 1, and data_1_out = 0 on the cycle after.
- Read with oe = 0, and a write: valid stays 0 and data_out stays 0.
- Reset asserted midway through a read stream: outputs go to 0 immediately, busy = 1, and the clear sweep restarts. Previously written data reads back as 0 afterwards.
- With MEMORY_BANKED_OUT_REG_EN defined: rerun the back-to-back scenario above and require 2-cycle latency.
